// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default bit timing.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    // 50 MHz clock at 115200 bps
    localparam int CLKS_PER_BIT_DEF = 434;
    localparam int CNT_W_DEF        = 9;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-offer handshake between a producer and the UART transmitter.
interface uart_tx_if;

    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period down-counter; tick marks the last cycle of each bit period.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic clock,
    input  logic reset_n,
    input  logic restart,
    output logic tick,
    output logic pre_tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (restart || cnt == '0) begin
            cnt <= LAST;
        end else begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign tick     = (cnt == '0);
    // one cycle ahead of tick, lets tx_done be a flop aligned to the last cycle
    assign pre_tick = (cnt == CNT_W'(1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits, even parity, one stop bit, one-byte buffer.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic      clock,
    input  logic      reset_n,
    uart_tx_if.slave  bus,
    output logic      tx_out,
    output logic      busy,
    output logic      tx_done
);

    uart_state_t state;
    logic [7:0]  hold;
    logic [7:0]  shreg;
    logic [2:0]  idx;
    logic        ready;
    logic        par;
    logic        tick;
    logic        pre_tick;
    logic        restart;
    logic        load;

    assign restart      = (state == IDLE);
    assign load         = !ready &&
                          ((state == IDLE) || (state == STOP && tick));
    assign bus.tx_ready = ready;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_W       (CNT_W)
    ) u_baud (
        .clock   (clock),
        .reset_n (reset_n),
        .restart (restart),
        .tick    (tick),
        .pre_tick(pre_tick)
    );

    // load and accept are exclusive: load needs a full buffer, accept an empty one
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready <= 1'b1;
            hold  <= '0;
        end else if (load) begin
            ready <= 1'b1;
        end else if (bus.tx_valid && ready) begin
            ready <= 1'b0;
            hold  <= bus.tx_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            tx_out  <= 1'b1;
            busy    <= 1'b0;
            tx_done <= 1'b0;
            shreg   <= '0;
            par     <= 1'b0;
            idx     <= '0;
        end else begin
            tx_done <= (state == STOP) && pre_tick;
            case (state)
                IDLE: begin
                    if (load) begin
                        state  <= START;
                        shreg  <= hold;
                        par    <= even_parity(hold);
                        tx_out <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state  <= DATA;
                        tx_out <= shreg[0];
                        shreg  <= {1'b0, shreg[7:1]};
                        idx    <= '0;
                    end
                end
                DATA: begin
                    if (tick) begin
                        idx <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state  <= PARITY;
                            tx_out <= par;
                        end else begin
                            tx_out <= shreg[0];
                            shreg  <= {1'b0, shreg[7:1]};
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        state  <= STOP;
                        tx_out <= 1'b1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (load) begin
                            state  <= START;
                            shreg  <= hold;
                            par    <= even_parity(hold);
                            tx_out <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            busy   <= 1'b0;
                            tx_out <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_out <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: fast instance for framing, slow one for loopback.
module tb_uart_tx;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    uart_tx_if f();
    uart_tx_if s();

    logic f_out, f_busy, f_done;
    logic s_out, s_busy, s_done;

    uart_tx #(.CLKS_PER_BIT(16), .CNT_W(4)) u_fast (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (f.slave),
        .tx_out (f_out),
        .busy   (f_busy),
        .tx_done(f_done)
    );

    uart_tx #(.CLKS_PER_BIT(434), .CNT_W(9)) u_slow (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (s.slave),
        .tx_out (s_out),
        .busy   (s_busy),
        .tx_done(s_done)
    );

    typedef struct {
        logic [7:0] data;
        logic       par;
        bit         b2b;
    } exp_t;

    exp_t q[$];
    int   vecs = 0;
    int   errs = 0;
    int   spurious = 0;
    bit   mon_en = 0;
    bit   mon_busy = 0;

    function automatic void check(input string name,
                                  input logic [31:0] got,
                                  input logic [31:0] want);
        vecs++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endfunction

    // monitor: pops one expected frame per start bit seen on the fast line
    initial begin
        exp_t        e;
        logic [10:0] bits;
        bit          just_ended;
        bit          ok;
        bit          bz;
        int          dhit;
        int          dpos;
        just_ended = 0;
        forever begin
            @(negedge clock);
            if (mon_en && just_ended && q.size() != 0 && q[0].b2b)
                check("gap", 32'(f_out), 0);
            just_ended = 0;
            if (mon_en && f_out === 1'b0) begin
                if (q.size() == 0) begin
                    spurious++;
                end else begin
                    e = q.pop_front();
                    mon_busy = 1;
                    bits = {1'b1, e.par, e.data, 1'b0};
                    dhit = 0;
                    dpos = -1;
                    bz = 1;
                    ok = 1;
                    for (int i = 0; i < 176; i++) begin
                        if (i != 0) @(negedge clock);
                        if (f_out !== bits[i/16]) ok = 0;
                        if (f_done === 1'b1) begin
                            dhit++;
                            dpos = i;
                        end
                        if (f_busy !== 1'b1) bz = 0;
                        if (i % 16 == 15) begin
                            check($sformatf("bit%0d_of_%02h_want_%0b",
                                  i / 16, e.data, bits[i/16]),
                                  32'(ok), 1);
                            ok = 1;
                        end
                    end
                    check($sformatf("done_count_%02h", e.data), dhit, 1);
                    check($sformatf("done_pos_%02h", e.data), dpos, 175);
                    check($sformatf("busy_%02h", e.data), 32'(bz), 1);
                    mon_busy = 0;
                    just_ended = 1;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic par,
                        input bit b2b, input bit push);
        int n;
        @(negedge clock);
        f.tx_valid = 1'b1;
        f.tx_data  = d;
        n = 0;
        while (f.tx_ready !== 1'b1 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (f.tx_ready !== 1'b1) check("accept_timeout", 0, 1);
        else if (push) q.push_back('{d, par, b2b});
        @(negedge clock);
        f.tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((q.size() != 0 || mon_busy || f_busy !== 1'b0) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        check({name, "_drain"}, 32'(q.size() == 0 && !mon_busy), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] rx;
        logic       rx_start, rx_par, rx_stop, rx_err;
        bit         rdy_seen, done_seen, line_low;
        int         n;

        f.tx_valid = 1'b0;
        f.tx_data  = '0;
        s.tx_valid = 1'b0;
        s.tx_data  = '0;
        reset_n    = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_out",   32'(f_out), 1);
        check("rst_ready", 32'(f.tx_ready), 1);
        check("rst_busy",  32'(f_busy), 0);
        check("rst_done",  32'(f_done), 0);
        reset_n = 1'b1;
        mon_en  = 1;

        // A5: parity 0, start bit on the edge after acceptance
        send(8'hA5, 1'b0, 0, 1);
        check("lat_hold", 32'(f_out), 1);
        @(negedge clock);
        check("lat_start", 32'(f_out), 0);
        wait_idle("a5");

        send(8'h07, 1'b1, 0, 1);
        wait_idle("07");

        // loopback through a simple receiver on the 434-cycle instance
        @(negedge clock);
        s.tx_valid = 1'b1;
        s.tx_data  = 8'h07;
        @(negedge clock);
        s.tx_valid = 1'b0;
        n = 0;
        while (s_out !== 1'b0 && n < 10000) begin
            @(negedge clock);
            n++;
        end
        if (s_out !== 1'b0) begin
            check("rx_start_timeout", 0, 1);
        end else begin
            repeat (216) @(negedge clock);
            rx_start = s_out;
            for (int b = 0; b < 8; b++) begin
                repeat (434) @(negedge clock);
                rx[b] = s_out;
            end
            repeat (434) @(negedge clock);
            rx_par = s_out;
            repeat (434) @(negedge clock);
            rx_stop = s_out;
            rx_err = (rx_start !== 1'b0) || (rx_stop !== 1'b1) ||
                     ((^rx) !== rx_par);
            check("rx_data",  32'(rx), 32'h07);
            check("rx_par",   32'(rx_par), 1);
            check("rx_error", 32'(rx_err), 0);
        end
        repeat (500) @(negedge clock);

        // back-to-back pair, then a third byte while the buffer is full
        send(8'h3C, 1'b0, 0, 1);
        send(8'hC3, 1'b0, 1, 1);
        @(negedge clock);
        f.tx_valid = 1'b1;
        f.tx_data  = 8'hFF;
        rdy_seen = 0;
        repeat (20) begin
            if (f.tx_ready !== 1'b0) rdy_seen = 1;
            @(negedge clock);
        end
        f.tx_valid = 1'b0;
        check("ff_blocked", 32'(rdy_seen), 0);
        wait_idle("3c_c3");

        // asynchronous reset in the middle of the data bits
        mon_en = 0;
        send(8'h96, 1'b0, 0, 0);
        repeat (40) @(negedge clock);
        check("pre_rst_busy", 32'(f_busy), 1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_out",   32'(f_out), 1);
        check("arst_ready", 32'(f.tx_ready), 1);
        check("arst_busy",  32'(f_busy), 0);
        done_seen = 0;
        line_low  = 0;
        repeat (3) begin
            @(negedge clock);
            if (f_done !== 1'b0) done_seen = 1;
        end
        reset_n = 1'b1;
        repeat (30) begin
            @(negedge clock);
            if (f_done !== 1'b0) done_seen = 1;
            if (f_out !== 1'b1) line_low = 1;
        end
        check("arst_no_done", 32'(done_seen), 0);
        check("arst_line_idle", 32'(line_low), 0);
        mon_en = 1;

        send(8'h55, 1'b0, 0, 1);
        wait_idle("55");
        repeat (20) @(negedge clock);
        check("spurious_frames", spurious, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
